// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and word/select types for the scoreboarded register file
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_NRD    = 2;
    localparam int DEF_NWR    = 2;
    localparam int DEF_SEL_W  = $clog2(DEF_NREGS);
    typedef logic [DEF_SEL_W-1:0]  regsel_t;
    typedef logic [DEF_DATA_W-1:0] regword_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with flush > reserve > writeback-clear priority
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NWR   = DEF_NWR,
    parameter int SEL_W = $clog2(NREGS),
    parameter int CNT_W = $clog2(NREGS + 1)
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [NWR-1:0]     wen,
    input  logic [NWR*SEL_W-1:0] wsel,
    input  logic               rsv_en,
    input  logic [SEL_W-1:0]   rsv_sel,
    input  logic               flush,
    output logic [NREGS-1:0]   busy,
    output logic [CNT_W-1:0]   busy_cnt
);
    logic [NREGS-1:0] clr;
    logic [NREGS-1:0] busy_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        clr      = '0;
        busy_nxt = '0;
        cnt_nxt  = '0;
        for (int p = 0; p < NWR; p++)
            if (wen[p]) clr[wsel[p*SEL_W +: SEL_W]] = 1'b1;
        // register 0 never becomes busy, so busy_cnt tops out at NREGS-1
        for (int i = 1; i < NREGS; i++)
            busy_nxt[i] = !flush && ((rsv_en && rsv_sel == SEL_W'(i)) || (busy[i] && !clr[i]));
        for (int i = 0; i < NREGS; i++)
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with integrated busy scoreboard.
// Define REGFILE_BYPASS_EN for write-first read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int NRD    = DEF_NRD,
    parameter int NWR    = DEF_NWR,
    parameter int SEL_W  = $clog2(NREGS)
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [NRD*SEL_W-1:0]      rsel,
    output logic [NRD*DATA_W-1:0]     rdat,
    output logic [NRD-1:0]            rbusy,
    output logic                      rd_stall,
    input  logic [NWR-1:0]            wen,
    input  logic [NWR*SEL_W-1:0]      wsel,
    input  logic [NWR*DATA_W-1:0]     wdat,
    input  logic                      rsv_en,
    input  logic [SEL_W-1:0]          rsv_sel,
    input  logic                      flush,
    output logic [$clog2(NREGS+1)-1:0] busy_cnt
);
    logic [DATA_W-1:0] mem [NREGS];
    logic [NREGS-1:0]  busy;

    regfile_scoreboard #(
        .NREGS(NREGS),
        .NWR  (NWR),
        .SEL_W(SEL_W)
    ) u_sb (
        .CLK     (CLK),
        .nRST    (nRST),
        .wen     (wen),
        .wsel    (wsel),
        .rsv_en  (rsv_en),
        .rsv_sel (rsv_sel),
        .flush   (flush),
        .busy    (busy),
        .busy_cnt(busy_cnt)
    );

    // later ports overwrite earlier ones, so the highest port index wins
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++)
                if (wen[p] && wsel[p*SEL_W +: SEL_W] != '0)
                    mem[wsel[p*SEL_W +: SEL_W]] <= wdat[p*DATA_W +: DATA_W];
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [SEL_W-1:0]  s;
        logic [DATA_W-1:0] d;
        logic              b;
        assign s = rsel[r*SEL_W +: SEL_W];
        always_comb begin
            d = mem[s];
            b = busy[s];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < NWR; p++)
                if (wen[p] && wsel[p*SEL_W +: SEL_W] == s && s != '0) begin
                    d = wdat[p*DATA_W +: DATA_W];
                    b = rsv_en && rsv_sel == s;
                end
`endif
        end
        assign rdat[r*DATA_W +: DATA_W] = d;
        assign rbusy[r] = b;
    end

    assign rd_stall = |rbusy;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed test of regfile_sb against a per-cycle behavioural model
module tb_regfile_sb;
    import regfile_pkg::*;
    localparam int SW = DEF_SEL_W;
    localparam int DW = DEF_DATA_W;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic [2*SW-1:0] rsel;
    logic [2*DW-1:0] rdat;
    logic [1:0]    rbusy;
    logic          rd_stall;
    logic [1:0]    wen;
    logic [2*SW-1:0] wsel;
    logic [2*DW-1:0] wdat;
    logic          rsv_en;
    regsel_t       rsv_sel;
    logic          flush;
    logic [5:0]    busy_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    regfile_sb dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .rsel    (rsel),
        .rdat    (rdat),
        .rbusy   (rbusy),
        .rd_stall(rd_stall),
        .wen     (wen),
        .wsel    (wsel),
        .wdat    (wdat),
        .rsv_en  (rsv_en),
        .rsv_sel (rsv_sel),
        .flush   (flush),
        .busy_cnt(busy_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model: register contents and pending-producer flags, updated in rule order
    regword_t mm [32];
    bit       mb [32];

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 32; i++) begin
                mm[i] = '0;
                mb[i] = 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wen[p] && wsel[p*SW +: SW] != 0) begin
                    mm[wsel[p*SW +: SW]] = wdat[p*DW +: DW];
                    mb[wsel[p*SW +: SW]] = 1'b0;
                end
            end
            if (rsv_en && rsv_sel != 0) mb[rsv_sel] = 1'b1;
            if (flush)
                for (int i = 0; i < 32; i++) mb[i] = 1'b0;
        end
    end

    function automatic logic [63:0] exp_rd(input int r, input bit want_busy);
        regsel_t  s;
        regword_t d;
        bit       b;
        s = rsel[r*SW +: SW];
        d = mm[s];
        b = mb[s];
        if (BYP)
            for (int p = 0; p < 2; p++)
                if (wen[p] && wsel[p*SW +: SW] == s && s != 0) begin
                    d = wdat[p*DW +: DW];
                    b = rsv_en && rsv_sel == s;
                end
        return want_busy ? 64'(b) : 64'(d);
    endfunction

    function automatic int mcnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mb[i]);
        return n;
    endfunction

    always @(negedge CLK) begin
        for (int r = 0; r < 2; r++) begin
            chk("m_rdat", rdat[r*DW +: DW], exp_rd(r, 1'b0));
            chk("m_rbusy", 64'(rbusy[r]), exp_rd(r, 1'b1));
        end
        chk("m_stall", 64'(rd_stall), exp_rd(0, 1'b1) | exp_rd(1, 1'b1));
        chk("m_cnt", 64'(busy_cnt), 64'(mcnt()));
    end

    task automatic idle();
        wen    = '0;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic wr(input int p, input int s, input logic [31:0] d);
        wen[p] = 1'b1;
        wsel[p*SW +: SW] = SW'(s);
        wdat[p*DW +: DW] = d;
    endtask

    task automatic rs(input int r, input int s);
        rsel[r*SW +: SW] = SW'(s);
    endtask

    task automatic rsv(input int s);
        rsv_en  = 1'b1;
        rsv_sel = SW'(s);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rsel = '0;
        wsel = '0;
        wdat = '0;
        rsv_sel = '0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        for (int s = 0; s < 32; s++) begin
            rs(0, s);
            rs(1, 31 - s);
            #1;
            chk("rst_rdat0", rdat[31:0], 0);
            chk("rst_rdat1", rdat[63:32], 0);
            chk("rst_rbusy", 64'(rbusy), 0);
            chk("rst_cnt", 64'(busy_cnt), 0);
        end
        tick();

        wr(0, 5, 32'hDEADBEEF);
        wr(1, 5, 32'h12345678);
        rs(0, 5);
        #1 chk("r5_same_cycle", rdat[31:0], BYP ? 64'h12345678 : 64'h0);
        tick();
        rs(0, 5);
        rs(1, 5);
        #1;
        chk("r5_port_hi_wins0", rdat[31:0], 64'h12345678);
        chk("r5_port_hi_wins1", rdat[63:32], 64'h12345678);

        wr(0, 0, 32'hFFFFFFFF);
        rs(0, 0);
        #1 chk("r0_bypass", rdat[31:0], 0);
        tick();
        #1 chk("r0_after", rdat[31:0], 0);

        rsv(7);
        tick();
        rs(0, 7);
        #1;
        chk("r7_busy", 64'(rbusy[0]), 1);
        chk("r7_stall", 64'(rd_stall), 1);
        chk("r7_cnt", 64'(busy_cnt), 1);
        wr(0, 7, 32'h55);
        tick();
        #1;
        chk("r7_wb_busy", 64'(rbusy[0]), 0);
        chk("r7_wb_cnt", 64'(busy_cnt), 0);
        chk("r7_wb_dat", rdat[31:0], 64'h55);

        rsv(3);
        wr(1, 3, 32'hAA);
        tick();
        rs(0, 3);
        #1;
        chk("r3_rsv_wins", 64'(rbusy[0]), 1);
        chk("r3_dat", rdat[31:0], 64'hAA);
        chk("r3_cnt", 64'(busy_cnt), 1);
        wr(0, 3, 32'hBB);
        tick();
        #1;
        chk("r3_wb_cnt", 64'(busy_cnt), 0);
        chk("r3_wb_dat", rdat[31:0], 64'hBB);

        rsv(1); tick();
        rsv(2); tick();
        rsv(4); tick();
        #1 chk("cnt3", 64'(busy_cnt), 3);
        flush = 1'b1;
        rsv(9);
        tick();
        rs(0, 9);
        #1;
        chk("flush_cnt", 64'(busy_cnt), 0);
        chk("flush_r9", 64'(rbusy[0]), 0);

        wr(0, 6, 32'h11); tick();
        rsv(6); tick();
        wr(0, 6, 32'h77);
        rs(0, 6);
        #1;
        chk("byp_dat", rdat[31:0], BYP ? 64'h77 : 64'h11);
        chk("byp_busy", 64'(rbusy[0]), BYP ? 64'h0 : 64'h1);
        tick();
        #1;
        chk("r6_dat", rdat[31:0], 64'h77);
        chk("r6_cnt", 64'(busy_cnt), 0);
        wr(1, 6, 32'h99);
        rsv(6);
        #1;
        chk("byp_rsv_dat", rdat[31:0], BYP ? 64'h99 : 64'h77);
        chk("byp_rsv_busy", 64'(rbusy[0]), BYP ? 64'h1 : 64'h0);
        tick();
        #1;
        chk("r6_rsv_dat", rdat[31:0], 64'h99);
        chk("r6_rsv_busy", 64'(rbusy[0]), 1);
        rsv(6); tick();
        #1 chk("rsv_again_cnt", 64'(busy_cnt), 1);
        wr(0, 10, 32'h1010); tick();
        rs(1, 10);
        #1;
        chk("wb_nonbusy_cnt", 64'(busy_cnt), 1);
        chk("r10_dat", rdat[63:32], 64'h1010);
        rsv(0); tick();
        rs(1, 0);
        #1;
        chk("rsv_r0_cnt", 64'(busy_cnt), 1);
        chk("rsv_r0_busy", 64'(rbusy[1]), 0);

        nRST = 1'b0;
        #1;
        chk("arst_r6", rdat[31:0], 0);
        chk("arst_busy", 64'(rbusy[0]), 0);
        chk("arst_cnt", 64'(busy_cnt), 0);
        rs(1, 10);
        #1 chk("arst_r10", rdat[63:32], 0);
        nRST = 1'b1;
        tick();

        for (int i = 0; i < 40; i++) begin
            wen     = 2'($urandom_range(0, 3));
            wsel    = {SW'($urandom_range(0, 7)), SW'($urandom_range(0, 7))};
            wdat    = {$urandom, $urandom};
            rsv_en  = 1'($urandom_range(0, 1));
            rsv_sel = SW'($urandom_range(0, 7));
            flush   = ($urandom_range(0, 7) == 0);
            rsel    = {SW'($urandom_range(0, 7)), SW'($urandom_range(0, 7))};
            @(posedge CLK);
            #1;
        end
        idle();
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with an integrated per-register scoreboard. It is the next-generation register file for the pipelined datapath. It supports NRD read ports and NWR write ports, and tracks a busy (pending-write) bit per register so decode can detect RAW hazards without a separate hazard unit. Register 0 is hardwired to zero and is never busy.

## Interface
Parameters:
- DATA_W, default 32: register width in bits.
- NREGS, default 32: register count; power of two, ≥ 2.
- NRD, default 2: number of read ports.
- NWR, default 2: number of write (writeback) ports.
- SEL_W, derived as $clog2(NREGS): register select width.

Ports:
- CLK, in, 1: clock; all state updates on posedge.
- nRST, in, 1: reset, asynchronous, active-low.
- rsel, in, NRD×SEL_W: read selects.
- rdat, out, NRD×DATA_W: read data.
- rbusy, out, NRD: busy bit of each rsel register.
- rd_stall, out, 1: OR of rbusy.
- wen, in, NWR: write enables.
- wsel, in, NWR×SEL_W: write selects.
- wdat, in, NWR×DATA_W: write data.
- rsv_en, in, 1: reserve request; sets busy on rsv_sel.
- rsv_sel, in, SEL_W: destination register to reserve.
- flush, in, 1: clears every busy bit.
- busy_cnt, out, $clog2(NREGS+1): number of busy registers.

## Operation
- Storage: NREGS×DATA_W registers.
- Reset clears all data to 0 and all busy bits to 0. Reset values: rdat=0, rbusy=0, rd_stall=0, busy_cnt=0.
- Write: on posedge, for each port p with wen[p] and wsel[p]≠0, reg[wsel[p]] ← wdat[p]. The same edge clears busy[wsel[p]].
- Two write ports targeting the same register: the higher port index wins the data. Busy is cleared once.
- Reserve: on posedge with rsv_en and rsv_sel≠0, busy[rsv_sel] ← 1.
- Reserve and writeback to the same register in one cycle: busy ends at 1, because the new producer wins. The write data is still stored.
- Flush: on posedge, all busy bits ← 0. Flush overrides a same-cycle reserve, which is dropped. Same-cycle writes are still performed.
- Register 0: reads return 0, writes are ignored, reserves are ignored, and it is never busy.
- busy_cnt: a registered popcount of the busy vector, updated on the same edge as busy. It never exceeds NREGS−1.
- Reserving an already-busy register leaves it busy. busy_cnt is unchanged.
- Writeback to a non-busy register is legal and does not change busy_cnt.

## Timing
- Reads are combinational from state: rdat and rbusy follow rsel in the same cycle.
- Without bypass, a write at edge N is visible on rdat after edge N, and a same-cycle read returns the old value.
- Reserve at edge N makes rbusy high after edge N.
- Writeback latency is 1 edge. Reserve-to-busy latency is 1 edge.
- nRST assertion mid-cycle immediately clears data, busy, and busy_cnt. Pending writes are lost.

## Configuration
- REGFILE_BYPASS_EN defined: read ports are write-first.
  - If any wen[p] with wsel[p]==rsel[r]≠0 in the current cycle, rdat[r] returns that wdat (highest p wins).
  - rbusy[r] is forced 0 for that read, unless rsv_en targets the same register in that cycle.
- REGFILE_BYPASS_EN undefined: no forwarding. rdat and rbusy reflect registered state only.

## Structure
- Package regfile_pkg holds:
  - parameter defaults;
  - typedef regsel_t (logic [SEL_W-1:0]);
  - typedef regword_t (logic [DATA_W-1:0]).
- Sub-module regfile_scoreboard holds the busy vector, reserve/clear/flush priority, and busy_cnt.
- The top module holds data storage, read muxes, and the bypass logic.

## Test plan
- Reset, then read all registers on both ports: every rdat=0, rbusy=0, busy_cnt=0.
- Write 0xDEADBEEF to r5 via port 0 and 0x12345678 to r5 via port 1 in the same cycle. Next cycle, read r5: 0x12345678. Write 0xFFFFFFFF to r0: a read of r0 stays 0.
- Reserve r7:
  - Next cycle: rbusy=1 for rsel=7, rd_stall=1, busy_cnt=1.
  - Writeback r7=0x55 on the following cycle. After that edge: rbusy=0, busy_cnt=0, rdat=0x55.
- Reserve r3 and write r3=0xAA in the same cycle: busy[3] stays 1, rdat=0xAA.
- Reserve r1, r2, r4 on successive cycles: busy_cnt=3. Then assert flush together with rsv r9: busy_cnt=0 and r9 not busy.
- With REGFILE_BYPASS_EN, write r6=0x77 while reading r6 in the same cycle: rdat=0x77, rbusy=0. Without the macro: rdat returns the old r6 value.
